// File: rtl/out_ser.sv
// Parallel-to-serial output register stage feeding the OQI pin of the output IO cell.
// Optional trailing even-parity bit when OUT_SER_PARITY_EN is defined.
module out_ser #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             OQI,
  output logic             busy,
  output logic             frame_done
);

`ifdef OUT_SER_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FL + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state, state_n;
  logic [CW-1:0] count, count_n;
  logic [FL-1:0] sr, sr_n;
  logic          oqi_n, busy_n, done_n;
  logic [FL-1:0] word;
  logic          last, accept;

  // Frame image in shift order; the parity bit sits where it leaves last.
`ifdef OUT_SER_PARITY_EN
  logic par;
  assign par  = ^data_in;
  assign word = MSB_FIRST ? {data_in, par} : {par, data_in};
`else
  assign word = data_in;
`endif

  assign last       = (state == SHIFT) && (count == CW'(FL - 1));
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      OQI        <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      sr         <= sr_n;
      OQI        <= oqi_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Next-state: load a new frame, shift the current one, or fall back to idle.
  always_comb begin
    state_n = state;
    count_n = count;
    sr_n    = sr;
    oqi_n   = IDLE_LEVEL;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      count_n = '0;
      oqi_n   = MSB_FIRST ? word[FL-1] : word[0];
      sr_n    = MSB_FIRST ? (word << 1) : (word >> 1);
      busy_n  = 1'b1;
    end else if (state == SHIFT && !last) begin
      count_n = count + CW'(1);
      oqi_n   = MSB_FIRST ? sr[FL-1] : sr[0];
      sr_n    = MSB_FIRST ? (sr << 1) : (sr >> 1);
      busy_n  = 1'b1;
      done_n  = (count_n == CW'(FL - 1));
    end else if (last) begin
      state_n = IDLE;
      count_n = '0;
    end
  end

endmodule

// File: tb/tb_out_ser.sv
// Scoreboard bench for out_ser: MSB-first and LSB-first instances share one stimulus stream.
module tb_out_ser;
  localparam int unsigned W = 8;
`ifdef OUT_SER_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif
  localparam logic IDLE_LVL = 1'b1;

  typedef struct {
    logic m;
    logic l;
    logic d;
  } exp_t;

  logic         IQC = 1'b0;
  logic         QRT = 1'b1;
  logic [W-1:0] data_in = 8'h5A;
  logic         load_valid = 1'b1;
  logic         ready_m, oqi_m, busy_m, done_m;
  logic         ready_l, oqi_l, busy_l, done_l;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  out_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LVL)) dut_m (
    .IQC(IQC), .QRT(QRT), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .OQI(oqi_m), .busy(busy_m), .frame_done(done_m));

  out_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LVL)) dut_l (
    .IQC(IQC), .QRT(QRT), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .OQI(oqi_l), .busy(busy_l), .frame_done(done_l));

  always #5 IQC = ~IQC;

  function automatic void chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected line image of one frame: bit k of the word order, then parity, done on the last.
  function automatic void push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int k = 0; k < int'(FL); k++) begin
      if (k < int'(W)) begin
        e.m = w[W-1-k];
        e.l = w[k];
      end else begin
        e.m = ^w;
        e.l = ^w;
      end
      e.d = (k == int'(FL) - 1);
      q.push_back(e);
    end
  endfunction

  // One clock edge; the model accepts when nothing is left of the current frame.
  task automatic step(output bit acc);
    @(posedge IQC);
    acc = load_valid && !QRT && (q.size() == 0);
    if (acc) push_frame(data_in);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] w, input int gap);
    bit acc;
    int n;
    load_valid = 1'b1;
    data_in    = w;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 64) begin
      step(acc);
      n++;
    end
    chk("accept_within_budget", acc, 1'b1);
    load_valid = 1'b0;
    data_in    = W'($urandom);
    repeat (gap) step(acc);
  endtask

  // Monitor: one expected entry per cycle that a frame bit is on the line.
  always @(negedge IQC) begin
    if (mon_en) begin
      chk("ready_m", ready_m, q.size() <= 1);
      chk("ready_l", ready_l, q.size() <= 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("busy_m", busy_m, 1'b1);
        chk("busy_l", busy_l, 1'b1);
        chk("oqi_msb", oqi_m, e.m);
        chk("oqi_lsb", oqi_l, e.l);
        chk("done_m", done_m, e.d);
        chk("done_l", done_l, e.d);
      end else begin
        chk("idle_busy_m", busy_m, 1'b0);
        chk("idle_busy_l", busy_l, 1'b0);
        chk("idle_oqi_m", oqi_m, IDLE_LVL);
        chk("idle_oqi_l", oqi_l, IDLE_LVL);
        chk("idle_done_m", done_m, 1'b0);
        chk("idle_done_l", done_l, 1'b0);
      end
    end
  end

  initial begin
    bit acc;
    step(acc);
    mon_en = 1'b1;
    repeat (2) step(acc);
    #1 QRT = 1'b0;
    load_valid = 1'b0;
    step(acc);

    offer(8'hA5, 2);
    offer(8'h0F, 0);
    offer(8'hF0, 0);
    offer(8'h3C, 3);

    // Abort a frame of 0x00 between edges during its fourth bit.
    offer(8'h00, 0);
    repeat (3) step(acc);
    #1 QRT = 1'b1;
    q.delete();
    #1;
    chk("abort_oqi_m", oqi_m, IDLE_LVL);
    chk("abort_oqi_l", oqi_l, IDLE_LVL);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_done", done_m, 1'b0);
    chk("abort_ready", ready_m, 1'b1);
    step(acc);
    #1 QRT = 1'b0;
    offer(8'hC3, 1);

    repeat (80) offer(W'($urandom), int'($urandom_range(0, 2)));
    repeat (FL + 3) step(acc);
    chk("drained", q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
